// File: rtl/sdram_rd_uart_tx_pkg.sv
// rtl/sdram_rd_uart_tx_pkg.sv - shared rates, baud divider derivation and FSM encodings
package sdram_rd_uart_tx_pkg;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 115_200;

  // Clocks per serial bit; integer division, caller guarantees a result >= 2.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Word-level sequencing: SEND covers the START/DATA/STOP span of both bytes.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FETCH = 2'd1,
    W_LATCH = 2'd2,
    W_SEND  = 2'd3
  } word_state_e;

  // Byte serializer states.
  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } byte_state_e;

endpackage

// File: rtl/sdram_rd_uart_tx_if.sv
// rtl/sdram_rd_uart_tx_if.sv - SDRAM read-side FIFO port
interface sdram_rd_uart_tx_if;
  logic        r_fifo_rclk;
  logic        r_fifo_rreq;
  logic [15:0] sys_r_data;
  logic [10:0] r_fifo_rusedw;

  modport master (
    output r_fifo_rclk,
    output r_fifo_rreq,
    input  sys_r_data,
    input  r_fifo_rusedw
  );

  modport slave (
    input  r_fifo_rclk,
    input  r_fifo_rreq,
    output sys_r_data,
    output r_fifo_rusedw
  );
endinterface

// File: rtl/sdram_rd_uart_tx_uart_tx_byte.sv
// rtl/sdram_rd_uart_tx_uart_tx_byte.sv - 8N1 byte serializer with back-to-back restart
module uart_tx_byte
  import sdram_rd_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_din,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_done_next,
  output logic       o_tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);

  byte_state_e   r_state;
  byte_state_e   w_next;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;
  logic          w_load;

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);
  // A start during the last stop cycle chains the next byte with no idle gap.
  assign w_load    = i_start && ((r_state == B_IDLE) || ((r_state == B_STOP) && w_bit_end));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= B_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: advance at bit boundaries, leave DATA after bit 7
  always_comb begin
    w_next = r_state;
    case (r_state)
      B_IDLE:  if (i_start) w_next = B_START;
      B_START: if (w_bit_end) w_next = B_DATA;
      B_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_next = B_STOP;
      B_STOP:  if (w_bit_end) w_next = i_start ? B_START : B_IDLE;
      default: w_next = B_IDLE;
    endcase
  end

  // Baud/bit counters, shift register and registered line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      if ((r_state == B_IDLE) || w_bit_end) r_baud_cnt <= '0;
      else                                  r_baud_cnt <= r_baud_cnt + 1'b1;

      if (w_load) begin
        r_shift   <= i_din;
        r_bit_cnt <= '0;
        r_tx      <= 1'b0;
      end else if ((r_state == B_START) && w_bit_end) begin
        r_tx <= r_shift[0];
      end else if ((r_state == B_DATA) && w_bit_end) begin
        if (r_bit_cnt == 3'd7) begin
          r_tx <= 1'b1;
        end else begin
          r_tx      <= r_shift[1];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  assign o_busy      = (r_state != B_IDLE);
  assign o_done      = (r_state == B_STOP) && w_bit_end;
  assign o_done_next = (r_state == B_STOP) && (r_baud_cnt == BAUD_PRE);
  assign o_tx        = r_tx;

endmodule

// File: rtl/sdram_rd_uart_tx.sv
// rtl/sdram_rd_uart_tx.sv - drains 16-bit FIFO words and sends them as two UART bytes, low first
module sdram_rd_uart_tx
  import sdram_rd_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int BAUD_DIV  = baud_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_en,
  sdram_rd_uart_tx_if.master        fifo,
  output logic                      uart_tx,
  output logic                      tx_busy,
  output logic                      word_done
);

  word_state_e r_state;
  word_state_e w_next;
  logic [7:0]  r_word_hi;
  logic        r_byte_sel;
  logic        r_rreq;
  logic        r_busy;
  logic        r_word_done;
  logic        w_start;
  logic [7:0]  w_din;
  logic        w_byte_busy;
  logic        w_byte_done;
  logic        w_byte_done_next;

  assign fifo.r_fifo_rclk = clk;

  // Low byte goes straight from the FIFO output during LATCH; high byte from the held word.
  assign w_start = (r_state == W_LATCH) ||
                   ((r_state == W_SEND) && w_byte_done && !r_byte_sel);
  assign w_din   = (r_state == W_LATCH) ? fifo.sys_r_data[7:0] : r_word_hi;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= W_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: one read in flight, return to IDLE after the high byte's stop bit
  always_comb begin
    w_next = r_state;
    case (r_state)
      W_IDLE:  if (tx_en && (fifo.r_fifo_rusedw != 11'd0) && !w_byte_busy) w_next = W_FETCH;
      W_FETCH: w_next = W_LATCH;
      W_LATCH: w_next = W_SEND;
      W_SEND:  if (w_byte_done && r_byte_sel) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Word register, byte select and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_hi   <= '0;
      r_byte_sel  <= 1'b0;
      r_rreq      <= 1'b0;
      r_busy      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      if (r_state == W_LATCH) begin
        r_word_hi  <= fifo.sys_r_data[15:8];
        r_byte_sel <= 1'b0;
      end else if ((r_state == W_SEND) && w_byte_done && !r_byte_sel) begin
        r_byte_sel <= 1'b1;
      end
      r_rreq      <= (w_next == W_FETCH);
      r_busy      <= (w_next != W_IDLE);
      r_word_done <= (r_state == W_SEND) && r_byte_sel && w_byte_done_next;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start),
    .i_din       (w_din),
    .o_busy      (w_byte_busy),
    .o_done      (w_byte_done),
    .o_done_next (w_byte_done_next),
    .o_tx        (uart_tx)
  );

  assign fifo.r_fifo_rreq = r_rreq;
  assign tx_busy          = r_busy;
  assign word_done        = r_word_done;

endmodule

// File: tb/tb_sdram_rd_uart_tx.sv
// tb/tb_sdram_rd_uart_tx.sv - directed bench with FIFO model and 8N1 receiver
module tb_sdram_rd_uart_tx;

  localparam int BD = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_en;
  logic uart_tx;
  logic tx_busy;
  logic word_done;

  sdram_rd_uart_tx_if fif();

  sdram_rd_uart_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .fifo      (fif.master),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Non-showahead FIFO model: data appears the cycle after a request.
  logic [15:0] fifo_mem [0:255];
  logic [7:0]  fifo_wr = 8'd0;
  logic [7:0]  fifo_rd = 8'd0;
  assign fif.r_fifo_rusedw = {3'b000, 8'(fifo_wr - fifo_rd)};

  always @(posedge fif.r_fifo_rclk) begin
    if (fif.r_fifo_rreq === 1'b1) begin
      fif.sys_r_data <= fifo_mem[fifo_rd];
      fifo_rd        <= fifo_rd + 8'd1;
    end
  end

  // Request / word_done monitor
  int   rreq_cnt = 0;
  int   underflow = 0;
  int   rreq_wide = 0;
  int   wd_cnt = 0;
  int   wd_cyc = 0;
  int   rreq_cyc [0:255];
  logic prev_rreq = 1'b0;

  always @(negedge clk) begin
    if (fif.r_fifo_rreq === 1'b1) begin
      rreq_cyc[rreq_cnt] = cyc;
      rreq_cnt++;
      if (fif.r_fifo_rusedw == 11'd0) underflow++;
      if (prev_rreq) rreq_wide++;
    end
    prev_rreq = fif.r_fifo_rreq;
    if (word_done === 1'b1) begin
      wd_cnt++;
      wd_cyc = cyc;
    end
  end

  // 8N1 receiver sampling mid-bit
  int         rx_state = 0;
  int         rx_cnt = 0;
  int         rx_n = 0;
  int         rx_ferr = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_bytes [0:255];
  int         rx_start [0:255];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_state = 0;
    end else if (rx_state == 0) begin
      if (uart_tx === 1'b0) begin
        rx_state = 1;
        rx_cnt = 0;
        rx_start[rx_n] = cyc;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % BD) == (BD / 2)) begin
        if ((rx_cnt / BD) == 0) begin
          if (uart_tx !== 1'b0) rx_ferr++;
        end else if ((rx_cnt / BD) <= 8) begin
          rx_sh = {uart_tx, rx_sh[7:1]};
        end else begin
          if (uart_tx !== 1'b1) rx_ferr++;
          rx_bytes[rx_n] = rx_sh;
          rx_n++;
          rx_state = 0;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rreq(input int n, input int budget);
    for (int i = 0; i < budget && rreq_cnt < n; i++) @(negedge clk);
  endtask

  task automatic wait_wd(input int n, input int budget);
    for (int i = 0; i < budget && wd_cnt < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[fifo_wr] = w;
    fifo_wr = fifo_wr + 8'd1;
  endtask

  logic [7:0]  e3 [0:5];
  logic [15:0] rnd [0:99];

  initial begin
    rst_n = 1'b0;
    tx_en = 1'b0;

    // Reset state
    cycles(3);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_rreq", fif.r_fifo_rreq, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_word_done", word_done, 0);
    rst_n = 1'b1;
    cycles(2);
    chk("idle_uart_tx", uart_tx, 1);

    // Empty FIFO with tx_en high: nothing happens
    tx_en = 1'b1;
    cycles(1000);
    chk("empty_rreq_cnt", rreq_cnt, 0);
    chk("empty_busy", tx_busy, 0);
    chk("empty_uart_tx", uart_tx, 1);
    chk("empty_rx_n", rx_n, 0);

    // Single word A55A
    push(16'hA55A);
    wait_rreq(1, 20);
    chk("a55a_rreq_cnt", rreq_cnt, 1);
    wait_wd(1, 400);
    chk("a55a_wd_cnt", wd_cnt, 1);
    chk("a55a_wd_latency", wd_cyc - rreq_cyc[0], 201);
    cycles(5);
    chk("a55a_rx_n", rx_n, 2);
    chk("a55a_byte0", rx_bytes[0], 8'h5A);
    chk("a55a_byte1", rx_bytes[1], 8'hA5);
    chk("a55a_start_lat", rx_start[0] - rreq_cyc[0], 2);
    chk("a55a_no_gap", rx_start[1] - rx_start[0], 100);
    chk("a55a_ferr", rx_ferr, 0);
    chk("a55a_busy_after", tx_busy, 0);
    chk("a55a_wd_pulse", wd_cnt, 1);

    // Three back-to-back words
    push(16'h0001);
    push(16'h0203);
    push(16'h0405);
    wait_wd(4, 1000);
    chk("b2b_wd_cnt", wd_cnt, 4);
    chk("b2b_rreq_cnt", rreq_cnt, 4);
    chk("b2b_gap1", rreq_cyc[2] - rreq_cyc[1], 203);
    chk("b2b_gap2", rreq_cyc[3] - rreq_cyc[2], 203);
    cycles(5);
    chk("b2b_rx_n", rx_n, 8);
    e3[0] = 8'h01; e3[1] = 8'h00; e3[2] = 8'h03;
    e3[3] = 8'h02; e3[4] = 8'h05; e3[5] = 8'h04;
    for (int i = 0; i < 6; i++) chk("b2b_byte", rx_bytes[2 + i], e3[i]);
    chk("b2b_ferr", rx_ferr, 0);

    // tx_en dropped mid-word
    push(16'hBEEF);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    wait_rreq(5, 20);
    cycles(50);
    tx_en = 1'b0;
    wait_wd(5, 400);
    cycles(300);
    chk("txen_wd_cnt", wd_cnt, 5);
    chk("txen_rreq_cnt", rreq_cnt, 5);
    chk("txen_busy", tx_busy, 0);
    chk("txen_rx_n", rx_n, 10);
    chk("txen_byte_lo", rx_bytes[8], 8'hEF);
    chk("txen_byte_hi", rx_bytes[9], 8'hBE);
    chk("txen_usedw", fif.r_fifo_rusedw, 4);
    fifo_wr = fifo_rd;

    // Reset during low-byte data bits
    tx_en = 1'b1;
    push(16'h1234);
    wait_rreq(6, 20);
    cycles(25);
    chk("rst_mid_line_low", uart_tx, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line_high", uart_tx, 1);
    chk("rst_mid_busy", tx_busy, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    chk("rst_after_line", uart_tx, 1);
    chk("rst_no_reread", rreq_cnt, 6);
    chk("rst_rx_n", rx_n, 10);
    push(16'h00FF);
    wait_rreq(7, 20);
    wait_wd(6, 400);
    cycles(5);
    chk("rst_next_rx_n", rx_n, 12);
    chk("rst_next_lo", rx_bytes[10], 8'hFF);
    chk("rst_next_hi", rx_bytes[11], 8'h00);
    chk("rst_next_start", rx_start[10] - rreq_cyc[6], 2);
    chk("rst_next_ferr", rx_ferr, 0);

    // 100 random words
    for (int i = 0; i < 100; i++) begin
      rnd[i] = 16'($urandom);
      push(rnd[i]);
    end
    wait_wd(106, 100 * 203 + 500);
    chk("rnd_wd_cnt", wd_cnt, 106);
    chk("rnd_rreq_cnt", rreq_cnt, 107);
    cycles(300);
    chk("rnd_rx_n", rx_n, 212);
    for (int i = 0; i < 100; i++) begin
      chk("rnd_lo", rx_bytes[12 + 2 * i], rnd[i][7:0]);
      chk("rnd_hi", rx_bytes[13 + 2 * i], rnd[i][15:8]);
    end
    chk("rnd_ferr", rx_ferr, 0);
    chk("rnd_underflow", underflow, 0);
    chk("rnd_rreq_wide", rreq_wide, 0);
    chk("rnd_usedw", fif.r_fifo_rusedw, 0);
    chk("rnd_busy", tx_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
